// File: rtl/tt_pkg.sv
// Shared types, op codes and the reference gate function for the truth-table checker.
package tt_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ERR_W  = 3;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned NVEC   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  // Golden response of the 2-input gate for a given op and stimulus.
  function automatic logic expected_out(input logic [1:0] op, input logic a, input logic b);
    logic y;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = ~(a & b);
    endcase
    return y;
  endfunction

endpackage

// File: rtl/tt_settle_cnt.sv
// Loadable 4-bit down-counter that stops at zero; times the settle window per vector.
module tt_settle_cnt
  import tt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tt_stim_checker.sv
// Drives all four {a,b} vectors into a 2-input gate, checks its response and reports per-vector errors.
module tt_stim_checker
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [1:0]  GATE_OP    = 2'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [NVEC-1:0]  fail_vec
);

  state_e             state_q, state_d;
  logic               start_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         ab_q, ab_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [NVEC-1:0]    fail_q, fail_d;
  logic               cnt_load_c;
  logic               cnt_zero;
  logic               mismatch_c;

  // Settle window: load SETTLE_CYC-1 so SETTLE spans exactly SETTLE_CYC cycles.
  tt_settle_cnt u_settle_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load_c),
    .value (CNT_W'(SETTLE_CYC - 1)),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      idx_q   <= '0;
      ab_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      idx_q   <= idx_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_q) state_d = SETTLE;
      SETTLE:  if (cnt_zero) state_d = SAMPLE;
      SAMPLE:  state_d = (idx_q == IDX_W'(NVEC - 1)) ? DONE : SETTLE;
      DONE:    if (start_q) state_d = SETTLE;
      default: state_d = IDLE;
    endcase
  end

  assign mismatch_c = (y_in != expected_out(GATE_OP, idx_q[1], idx_q[0]));

  always_comb begin
    idx_d      = idx_q;
    ab_d       = ab_q;
    err_d      = err_q;
    fail_d     = fail_q;
    cnt_load_c = (state_q != SETTLE) && (state_d == SETTLE);

    if ((state_q == IDLE || state_q == DONE) && start_q) begin
      idx_d  = '0;
      ab_d   = 2'b00;
      err_d  = '0;
      fail_d = '0;
    end else if (state_q == SAMPLE) begin
      if (mismatch_c) begin
        err_d         = err_q + ERR_W'(1);
        fail_d[idx_q] = 1'b1;
      end
      if (idx_q != IDX_W'(NVEC - 1)) begin
        idx_d = idx_q + IDX_W'(1);
        ab_d  = idx_d;
      end
    end

    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == '0);
  end

  assign a        = ab_q[1];
  assign b        = ab_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;

endmodule

// File: tb/tb_tt_stim_checker.sv
// Directed bench: OR checker with default settle, plus an XOR checker with one-cycle settle.
module tb_tt_stim_checker;
  import tt_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start_x;
  logic       a, b, y_in, busy, done, pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_vec;
  logic       a_x, b_x, y_x, busy_x, done_x, pass_x;
  logic [2:0] err_x;
  logic [3:0] fail_x;
  int         mode;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  // mode 0: correct OR, 1: stuck at 0, 2: AND instead of OR
  assign y_in = (mode == 0) ? (a | b) : (mode == 1) ? 1'b0 : (a & b);
  assign y_x  = a_x ^ b_x;

  tt_stim_checker #(.SETTLE_CYC(2), .GATE_OP(2'd1)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_vec(fail_vec)
  );

  tt_stim_checker #(.SETTLE_CYC(1), .GATE_OP(2'd2)) dut_x (
    .clk(clk), .rst(rst), .start(start_x), .a(a_x), .b(b_x), .y_in(y_x),
    .busy(busy_x), .done(done_x), .pass(pass_x), .err_cnt(err_x), .fail_vec(fail_x)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ab"},   8'({a, b}),  8'h0);
    chk({tag, ".busy"}, 8'(busy),    8'h0);
    chk({tag, ".done"}, 8'(done),    8'h0);
    chk({tag, ".pass"}, 8'(pass),    8'h0);
    chk({tag, ".err"},  8'(err_cnt), 8'h0);
    chk({tag, ".fail"}, 8'(fail_vec), 8'h0);
  endtask

  // Full OR run: start sampled at edge t, vectors 3 cycles each from t+1, done at t+13.
  task automatic run_or(input string tag, input logic [2:0] e_err, input logic [3:0] e_fail,
                        input logic e_pass, input bit repulse);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".busy_t"}, 8'(busy), 8'h0);
    for (int c = 1; c <= 13; c++) begin
      if (repulse && c == 5) start = 1'b1;
      tick();
      start = 1'b0;
      if (c == 1)  chk({tag, ".busy_t1"}, 8'(busy), 8'h1);
      if (c == 2)  chk({tag, ".ab00"}, 8'({a, b}), 8'h0);
      if (c == 4)  chk({tag, ".ab01"}, 8'({a, b}), 8'h1);
      if (c == 7)  chk({tag, ".ab10"}, 8'({a, b}), 8'h2);
      if (c == 10) chk({tag, ".ab11"}, 8'({a, b}), 8'h3);
      if (c == 12) chk({tag, ".done_t12"}, 8'(done), 8'h0);
    end
    chk({tag, ".done_t13"}, 8'(done), 8'h1);
    chk({tag, ".busy_end"}, 8'(busy), 8'h0);
    chk({tag, ".err"},  8'(err_cnt),  8'(e_err));
    chk({tag, ".fail"}, 8'(fail_vec), 8'(e_fail));
    chk({tag, ".pass"}, 8'(pass),     8'(e_pass));
    chk({tag, ".ab_hold"}, 8'({a, b}), 8'h3);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_x = 1'b0; mode = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_all_zero("reset");
    chk("reset.state", 8'(dut.state_q), 8'(IDLE));

    // Correct OR gate
    mode = 0;
    run_or("or_ok", 3'd0, 4'b0000, 1'b1, 1'b0);

    // Stuck-at-0 output, started from DONE
    mode = 1;
    run_or("stuck0", 3'd3, 4'b1110, 1'b0, 1'b0);

    // Start in DONE clears the previous result one cycle after the pulse is sampled
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("restart.done", 8'(done), 8'h0);
    chk("restart.err",  8'(err_cnt), 8'h0);
    chk("restart.fail", 8'(fail_vec), 8'h0);
    chk("restart.busy", 8'(busy), 8'h1);
    repeat (14) tick();
    chk("restart.pass", 8'(pass), 8'h1);

    // AND wired where OR is expected
    mode = 2;
    run_or("and_gate", 3'd2, 4'b0110, 1'b0, 1'b0);

    // Re-pulse while busy is ignored
    mode = 0;
    run_or("repulse", 3'd0, 4'b0000, 1'b1, 1'b1);

    // Reset during the third vector's settle window
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("abort.ab10", 8'({a, b}), 8'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("abort");
    chk("abort.state", 8'(dut.state_q), 8'(IDLE));
    run_or("after_abort", 3'd0, 4'b0000, 1'b1, 1'b0);

    // Reset wins over a simultaneous start
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    tick();
    tick();
    chk("rst_prio.busy", 8'(busy), 8'h0);
    chk("rst_prio.state", 8'(dut.state_q), 8'(IDLE));

    // XOR checker with one-cycle settle: done at t+9
    start_x = 1'b1;
    tick();
    start_x = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) chk("xor.ab00", 8'({a_x, b_x}), 8'h0);
      if (c == 3) chk("xor.ab01", 8'({a_x, b_x}), 8'h1);
      if (c == 5) chk("xor.ab10", 8'({a_x, b_x}), 8'h2);
      if (c == 7) chk("xor.ab11", 8'({a_x, b_x}), 8'h3);
      if (c == 8) chk("xor.done_t8", 8'(done_x), 8'h0);
    end
    chk("xor.done_t9", 8'(done_x), 8'h1);
    chk("xor.pass",    8'(pass_x), 8'h1);
    chk("xor.err",     8'(err_x),  8'h0);
    chk("xor.fail",    8'(fail_x), 8'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_stim_checker.md
TT_STIM_CHECKER -- requirements
Module: tt_stim_checker

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 2, giving settle cycles per vector (legal 1..15).
REQ-002 The block SHALL have parameter GATE_OP, default 2'd1, selecting the expected function: 0 AND, 1 OR, 2 XOR, 3 NAND.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle pulse that launches a truth-table run.
REQ-006 The block SHALL have ports a and b, output, 1 each, registered stimulus to the 2-input gate under test.
REQ-007 The block SHALL have port y_in, input, 1, the gate output fed back for checking.
REQ-008 The block SHALL have port busy, output, 1, high while a run is in progress.
REQ-009 The block SHALL have port done, output, 1, high (level) once a run completes, until the next start or rst.
REQ-010 The block SHALL have port pass, output, 1, equal to done AND (err_cnt == 0).
REQ-011 The block SHALL have port err_cnt, output, 3, the count of mismatched vectors (0..4).
REQ-012 The block SHALL have port fail_vec, output, 4, where bit i is set when vector i ({a,b}=i) mismatched.

Function
REQ-013 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-014 IDLE/DONE + start: the FSM SHALL clear err_cnt and fail_vec, set idx=0, {a,b}=2'b00, drop done, enter SETTLE, and load the settle counter.
REQ-015 SETTLE SHALL last exactly SETTLE_CYC cycles with a and b held stable, then go to SAMPLE.
REQ-016 SAMPLE SHALL last 1 cycle and compare y_in to expected(idx, GATE_OP); on mismatch err_cnt SHALL increment and fail_vec[idx] SHALL be set.
REQ-017 SAMPLE with idx<3: idx SHALL increment, {a,b} SHALL become the new idx on the next edge, and the FSM SHALL re-enter SETTLE.
REQ-018 SAMPLE with idx==3: the FSM SHALL enter DONE, set done=1, and hold a and b at 2'b11.
REQ-019 Latency: with start sampled at edge t, done SHALL rise at edge t+1+4*(SETTLE_CYC+1); with the default, t+13.
REQ-020 busy SHALL be 1 exactly in SETTLE and SAMPLE.
REQ-021 start while busy SHALL be ignored, with no restart and no counter change.
REQ-022 start in DONE SHALL begin a fresh run identical to one started from IDLE.
REQ-023 err_cnt SHALL NOT wrap; its maximum is 4, by construction.
REQ-024 The expected function SHALL be combinational on idx[1] (a) and idx[0] (b) only; y_in is sampled only in SAMPLE, and X/Z elsewhere is ignored.

Reset
REQ-025 On rst=1 at a rising edge, the FSM SHALL go to IDLE, with a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0 and idx=0.
REQ-026 rst asserted mid-run SHALL abort the run and give the same values as REQ-025; no partial result is kept.
REQ-027 rst SHALL take priority over a simultaneous start.

Structure
REQ-028 The shared package tt_pkg SHALL hold the state enum, the GATE_OP codes (OP_AND, OP_OR, OP_XOR, OP_NAND) and the function expected_out(op, a, b).
REQ-029 The block SHALL have one sub-module, tt_settle_cnt: a 4-bit loadable down-counter with load, value and zero flag.
REQ-030 The rest of the block SHALL be a single FSM plus registers.

Verification
REQ-031 The bench SHALL cover this case: GATE_OP=OR, y_in from a correct OR of a and b, start pulse -> {a,b} steps 00,01,10,11 with 3 cycles each; done at t+13; pass=1; err_cnt=0; fail_vec=0000.
REQ-032 The bench SHALL cover this case: GATE_OP=OR, y_in stuck at 0 -> err_cnt=3; fail_vec=1110; pass=0; done=1.
REQ-033 The bench SHALL cover this case: GATE_OP=OR, y_in = a AND b -> err_cnt=2; fail_vec=0110.
REQ-034 The bench SHALL cover this case: rst pulsed during the 3rd vector's SETTLE -> next cycle all outputs 0 and FSM in IDLE; a new start then completes normally.
REQ-035 The bench SHALL cover this case: start re-pulsed at t+5 while busy -> ignored; done still at t+13; then start in DONE -> done drops next cycle, err_cnt and fail_vec clear.
REQ-036 The bench SHALL cover this case: SETTLE_CYC=1, GATE_OP=XOR, y_in a correct XOR -> done at t+9; pass=1.
